rv3n_gsr_sb: RTL and testbench
==============================

Name: rv3n_gsr_sb

Overview:
- Parametrised multi-port general register file with an integrated per-register busy scoreboard and optional write-to-read bypass.
- Sits between ID (operand fetch, producer marking) and the commit/writeback stage (CH).
- Supplies operand data plus a per-operand ready flag, so ID can stall on RAW hazards without its own scoreboard.
- Register 0 is hardwired to zero and is never busy.

Parameters:
- XLEN, 32, register data width.
- RGBIT, 5, register index width; NREG = 2**RGBIT registers.
- RNUM, 2, number of read lanes (each lane has rs0 and rs1).
- WNUM, 2, number of write/clear lanes.
- SNUM, 2, number of busy-set lanes from ID.
- BYPASS, 1, 1 = same-cycle write data and clear forwarded to reads; 0 = reads see registered state only.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous active-high reset.
- id2gsr_rs0_order  in  RNUM*RGBIT  rs0 index per read lane.
- id2gsr_rs1_order  in  RNUM*RGBIT  rs1 index per read lane.
- gsr2id_rs0_data  out  RNUM*XLEN  rs0 data per lane.
- gsr2id_rs1_data  out  RNUM*XLEN  rs1 data per lane.
- gsr2id_rs0_rdy  out  RNUM  rs0 not pending per lane.
- gsr2id_rs1_rdy  out  RNUM  rs1 not pending per lane.
- id2gsr_set_order  in  SNUM*RGBIT  destination to mark busy per lane; 0 = no-op.
- ch2gsr_order  in  WNUM*RGBIT  writeback destination per lane; 0 = no-op.
- ch2gsr_data  in  WNUM*XLEN  writeback data per lane.
- ch2gsr_flush  in  1  clear all busy bits (pipeline flush).
- gsr2id_busy_cnt  out  RGBIT+1  number of busy registers, registered.

Behaviour:
- Reset (async):
  - all rg_file entries = 0; all busy bits = 0; gsr2id_busy_cnt = 0.
  - While reset is held, reads return 0 with rdy = 1.
- Write, 1-cycle latency:
  - A lane with order != 0 writes rg_file[order] on the next edge.
  - Multiple lanes to the same index: the lowest lane index wins (lane 0 = oldest = highest priority).
  - Writes to index 0 are discarded.
- Busy clear:
  - Any write lane with order = r, r != 0, clears busy[r] on the edge.
- Busy set:
  - Any set lane with index r, r != 0, sets busy[r] on the edge.
  - Set and clear of the same r in the same cycle: set wins. The new producer is younger than the retiring one.
- Flush:
  - ch2gsr_flush = 1 clears every busy bit on the edge.
  - It overrides same-cycle sets.
  - Register writes in the same cycle still occur.
- Read, combinational. For index r:
  - r = 0: data = 0, rdy = 1.
  - BYPASS=1 and any write lane targets r this cycle: data = the winning lane's ch2gsr_data (same priority rule), rdy = 1.
  - Otherwise: data = rg_file[r], rdy = ~busy[r].
  - BYPASS=0: data = rg_file[r], rdy = ~busy[r], ignoring same-cycle writes.
  - A same-cycle set never affects the current-cycle rdy; it is visible next cycle.
- Busy count:
  - gsr2id_busy_cnt = popcount of the next busy vector, registered.
  - Max value NREG-1, so RGBIT+1 bits is sufficient.
- Arithmetic/width:
  - Lane i occupies bits [i*W +: W] of each packed bus.
  - Out-of-range indices cannot occur because NREG = 2**RGBIT.
- Reset asserted mid-operation: state is cleared immediately, and any in-flight write in that cycle is lost.

Test Plan:
- Reset then read x5 on both lanes -> data 0x0, rdy 1, busy_cnt 0.
- Set x3 (lane 0); next cycle read x3 -> rdy 0, busy_cnt 1. Then write lane 1 x3 = 0xDEAD_BEEF: with BYPASS=1, same cycle data 0xDEADBEEF, rdy 1; next cycle rdy 1 from the file, busy_cnt 0.
- Write lanes 0 and 1 both to x7 with 0x11 / 0x22 -> next cycle x7 reads 0x11. Bypass in the write cycle also shows 0x11.
- Same cycle: set x4 and clear x4 via write 0x55 -> next cycle x4 data 0x55, rdy 0, busy_cnt 1.
- Set x1, x2, x9 over successive cycles, then assert flush together with set x10 -> next cycle all rdy 1, busy_cnt 0.
- Write x0 = 0xFFFF_FFFF and set x0 -> x0 reads 0, rdy 1, busy_cnt unchanged. Repeat with BYPASS=0: the write-cycle read of a pending target shows old data with rdy 0.

Source files
------------

// File: rtl/rv3n_gsr_sb_if.sv
// rv3n_gsr_sb_if: operand-fetch, busy-marking and writeback signals between
// ID / CH (master side) and the general register file scoreboard (slave side).
interface rv3n_gsr_sb_if #(
  parameter int XLEN  = 32,
  parameter int RGBIT = 5,
  parameter int RNUM  = 2,
  parameter int WNUM  = 2,
  parameter int SNUM  = 2
);
  logic [RNUM*RGBIT-1:0] id2gsr_rs0_order;
  logic [RNUM*RGBIT-1:0] id2gsr_rs1_order;
  logic [RNUM*XLEN-1:0]  gsr2id_rs0_data;
  logic [RNUM*XLEN-1:0]  gsr2id_rs1_data;
  logic [RNUM-1:0]       gsr2id_rs0_rdy;
  logic [RNUM-1:0]       gsr2id_rs1_rdy;
  logic [SNUM*RGBIT-1:0] id2gsr_set_order;
  logic [WNUM*RGBIT-1:0] ch2gsr_order;
  logic [WNUM*XLEN-1:0]  ch2gsr_data;
  logic                  ch2gsr_flush;
  logic [RGBIT:0]        gsr2id_busy_cnt;

  modport master (
    output id2gsr_rs0_order, id2gsr_rs1_order, id2gsr_set_order,
           ch2gsr_order, ch2gsr_data, ch2gsr_flush,
    input  gsr2id_rs0_data, gsr2id_rs1_data, gsr2id_rs0_rdy, gsr2id_rs1_rdy,
           gsr2id_busy_cnt
  );

  modport slave (
    input  id2gsr_rs0_order, id2gsr_rs1_order, id2gsr_set_order,
           ch2gsr_order, ch2gsr_data, ch2gsr_flush,
    output gsr2id_rs0_data, gsr2id_rs1_data, gsr2id_rs0_rdy, gsr2id_rs1_rdy,
           gsr2id_busy_cnt
  );
endinterface

// File: rtl/rv3n_gsr_sb.sv
// rv3n_gsr_sb: multi-port general register file with a per-register busy
// scoreboard. ID reads operands plus a ready flag and marks producers busy;
// the commit stage writes results back and retires the busy marks.
// Register 0 reads as zero and is never busy.
module rv3n_gsr_sb #(
  parameter int XLEN   = 32,
  parameter int RGBIT  = 5,
  parameter int RNUM   = 2,
  parameter int WNUM   = 2,
  parameter int SNUM   = 2,
  parameter int BYPASS = 1
) (
  input logic          clk,
  input logic          rst,
  rv3n_gsr_sb_if.slave bus
);
  localparam int NREG = 2 ** RGBIT;
  localparam int CW   = RGBIT + 1;

  logic [XLEN-1:0]  rg_file [NREG];
  logic [NREG-1:0]  busy;
  logic [NREG-1:0]  busy_nxt;
  logic [NREG-1:0]  wr_hit;
  logic [XLEN-1:0]  wr_val [NREG];
  logic [CW-1:0]    cnt_nxt;
  logic [CW-1:0]    busy_cnt;
  logic [RGBIT-1:0] wr_idx;
  logic [RGBIT-1:0] set_idx;
  logic [XLEN:0]    rd0;
  logic [XLEN:0]    rd1;

  // Resolve write lanes per register; walking from the top lane down lets lane 0 land last, so the oldest lane wins.
  always_comb begin
    wr_hit = '0;
    wr_idx = '0;
    for (int r = 0; r < NREG; r++) wr_val[r] = '0;
    for (int w = WNUM - 1; w >= 0; w--) begin
      wr_idx = bus.ch2gsr_order[w*RGBIT +: RGBIT];
      if (wr_idx != '0) begin
        wr_hit[wr_idx] = 1'b1;
        wr_val[wr_idx] = bus.ch2gsr_data[w*XLEN +: XLEN];
      end
    end
  end

  // Next busy vector: retire writebacks, then apply sets (younger producer wins), flush overrides everything.
  always_comb begin
    busy_nxt = busy & ~wr_hit;
    set_idx  = '0;
    for (int s = 0; s < SNUM; s++) begin
      set_idx = bus.id2gsr_set_order[s*RGBIT +: RGBIT];
      if (set_idx != '0) busy_nxt[set_idx] = 1'b1;
    end
    if (bus.ch2gsr_flush) busy_nxt = '0;
    busy_nxt[0] = 1'b0;
  end

  // Popcount of the next busy vector so the registered count tracks the registered busy bits.
  always_comb begin
    cnt_nxt = '0;
    for (int r = 1; r < NREG; r++) cnt_nxt = cnt_nxt + {{RGBIT{1'b0}}, busy_nxt[r]};
  end

  // Register file, busy bits and busy count; reset wipes any write in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) rg_file[r] <= '0;
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      for (int r = 1; r < NREG; r++) begin
        if (wr_hit[r]) rg_file[r] <= wr_val[r];
      end
      busy     <= busy_nxt;
      busy_cnt <= cnt_nxt;
    end
  end

  // One read port: {rdy, data}. Same-cycle sets are deliberately not consulted.
  function automatic logic [XLEN:0] rd_port(input logic [RGBIT-1:0] idx);
    logic [XLEN:0] res;
    if (rst || idx == '0)
      res = {1'b1, {XLEN{1'b0}}};
    else if (BYPASS != 0 && wr_hit[idx])
      res = {1'b1, wr_val[idx]};
    else
      res = {~busy[idx], rg_file[idx]};
    return res;
  endfunction

  // Combinational operand fetch for every read lane.
  always_comb begin
    bus.gsr2id_rs0_data = '0;
    bus.gsr2id_rs1_data = '0;
    bus.gsr2id_rs0_rdy  = '0;
    bus.gsr2id_rs1_rdy  = '0;
    rd0 = '0;
    rd1 = '0;
    for (int l = 0; l < RNUM; l++) begin
      rd0 = rd_port(bus.id2gsr_rs0_order[l*RGBIT +: RGBIT]);
      rd1 = rd_port(bus.id2gsr_rs1_order[l*RGBIT +: RGBIT]);
      bus.gsr2id_rs0_data[l*XLEN +: XLEN] = rd0[XLEN-1:0];
      bus.gsr2id_rs1_data[l*XLEN +: XLEN] = rd1[XLEN-1:0];
      bus.gsr2id_rs0_rdy[l] = rd0[XLEN];
      bus.gsr2id_rs1_rdy[l] = rd1[XLEN];
    end
  end

  assign bus.gsr2id_busy_cnt = busy_cnt;

endmodule

// File: tb/tb_rv3n_gsr_sb.sv
// tb_rv3n_gsr_sb: drives a bypassing and a non-bypassing register file with
// the same stimulus and compares both against a register/busy-array model.
module tb_rv3n_gsr_sb;
  localparam int XLEN  = 32;
  localparam int RGBIT = 5;
  localparam int RNUM  = 2;
  localparam int WNUM  = 2;
  localparam int SNUM  = 2;
  localparam int NREG  = 2 ** RGBIT;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  // Reference model state and the stimulus of the current cycle
  logic [XLEN-1:0] m_file [NREG];
  bit              m_busy [NREG];
  int              s_rs0 [RNUM];
  int              s_rs1 [RNUM];
  int              s_set [SNUM];
  int              s_wo  [WNUM];
  logic [XLEN-1:0] s_wd  [WNUM];
  bit              s_flush;

  rv3n_gsr_sb_if #(.XLEN(XLEN), .RGBIT(RGBIT), .RNUM(RNUM), .WNUM(WNUM), .SNUM(SNUM)) bus_b ();
  rv3n_gsr_sb_if #(.XLEN(XLEN), .RGBIT(RGBIT), .RNUM(RNUM), .WNUM(WNUM), .SNUM(SNUM)) bus_n ();

  rv3n_gsr_sb #(.XLEN(XLEN), .RGBIT(RGBIT), .RNUM(RNUM), .WNUM(WNUM), .SNUM(SNUM), .BYPASS(1))
    dut_b (.clk(clk), .rst(rst), .bus(bus_b));
  rv3n_gsr_sb #(.XLEN(XLEN), .RGBIT(RGBIT), .RNUM(RNUM), .WNUM(WNUM), .SNUM(SNUM), .BYPASS(0))
    dut_n (.clk(clk), .rst(rst), .bus(bus_n));

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard time limit so the run always ends
  initial begin
    #2000000;
    $display("[TB] FAIL timeout: got no finish, expected finish before time limit");
    $fatal(1, "[TB] time limit expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int modelCount();
    int n;
    n = 0;
    for (int r = 0; r < NREG; r++) if (m_busy[r]) n++;
    return n;
  endfunction

  task automatic modelReset();
    for (int r = 0; r < NREG; r++) begin
      m_file[r] = '0;
      m_busy[r] = 1'b0;
    end
  endtask

  // Expected operand for one read index under the current stimulus
  function automatic void refRead(input bit byp, input int idx, output logic [XLEN-1:0] d, output bit rdy);
    d   = m_file[idx];
    rdy = !m_busy[idx];
    if (rst || idx == 0) begin
      d   = '0;
      rdy = 1'b1;
      return;
    end
    if (byp) begin
      for (int w = 0; w < WNUM; w++) begin
        if (s_wo[w] == idx) begin
          d   = s_wd[w];
          rdy = 1'b1;
          return;
        end
      end
    end
  endfunction

  // Model state update at a clock edge: first matching write lane wins,
  // flush beats set, set beats clear
  task automatic modelEdge();
    bit              wr;
    bit              st;
    logic [XLEN-1:0] v;
    for (int r = 1; r < NREG; r++) begin
      wr = 1'b0;
      st = 1'b0;
      v  = '0;
      for (int w = 0; w < WNUM; w++) begin
        if (!wr && s_wo[w] == r) begin
          wr = 1'b1;
          v  = s_wd[w];
        end
      end
      for (int s = 0; s < SNUM; s++) if (s_set[s] == r) st = 1'b1;
      if (wr) m_file[r] = v;
      if (s_flush)  m_busy[r] = 1'b0;
      else if (st)  m_busy[r] = 1'b1;
      else if (wr)  m_busy[r] = 1'b0;
    end
  endtask

  task automatic clearStim();
    for (int l = 0; l < RNUM; l++) begin
      s_rs0[l] = 0;
      s_rs1[l] = 0;
    end
    for (int s = 0; s < SNUM; s++) s_set[s] = 0;
    for (int w = 0; w < WNUM; w++) begin
      s_wo[w] = 0;
      s_wd[w] = '0;
    end
    s_flush = 1'b0;
  endtask

  function automatic int rndIdx();
    if ($urandom_range(0, 3) == 0) return int'($urandom_range(0, NREG - 1));
    return int'($urandom_range(0, 7));
  endfunction

  task automatic randomStim();
    for (int l = 0; l < RNUM; l++) begin
      s_rs0[l] = rndIdx();
      s_rs1[l] = rndIdx();
    end
    for (int s = 0; s < SNUM; s++) s_set[s] = ($urandom_range(0, 2) == 0) ? rndIdx() : 0;
    for (int w = 0; w < WNUM; w++) begin
      s_wo[w] = ($urandom_range(0, 1) == 0) ? rndIdx() : 0;
      s_wd[w] = $urandom();
    end
    if ($urandom_range(0, 3) == 0) s_rs0[0] = s_wo[$urandom_range(0, WNUM - 1)];
    s_flush = ($urandom_range(0, 15) == 0);
  endtask

  task automatic drive();
    logic [RNUM*RGBIT-1:0] r0;
    logic [RNUM*RGBIT-1:0] r1;
    logic [SNUM*RGBIT-1:0] so;
    logic [WNUM*RGBIT-1:0] wo;
    logic [WNUM*XLEN-1:0]  wd;
    for (int l = 0; l < RNUM; l++) begin
      r0[l*RGBIT +: RGBIT] = s_rs0[l][RGBIT-1:0];
      r1[l*RGBIT +: RGBIT] = s_rs1[l][RGBIT-1:0];
    end
    for (int s = 0; s < SNUM; s++) so[s*RGBIT +: RGBIT] = s_set[s][RGBIT-1:0];
    for (int w = 0; w < WNUM; w++) begin
      wo[w*RGBIT +: RGBIT] = s_wo[w][RGBIT-1:0];
      wd[w*XLEN +: XLEN]   = s_wd[w];
    end
    bus_b.id2gsr_rs0_order = r0;  bus_n.id2gsr_rs0_order = r0;
    bus_b.id2gsr_rs1_order = r1;  bus_n.id2gsr_rs1_order = r1;
    bus_b.id2gsr_set_order = so;  bus_n.id2gsr_set_order = so;
    bus_b.ch2gsr_order     = wo;  bus_n.ch2gsr_order     = wo;
    bus_b.ch2gsr_data      = wd;  bus_n.ch2gsr_data      = wd;
    bus_b.ch2gsr_flush     = s_flush;
    bus_n.ch2gsr_flush     = s_flush;
  endtask

  task automatic checkReads();
    logic [XLEN-1:0] d;
    bit              k;
    for (int l = 0; l < RNUM; l++) begin
      refRead(1'b1, s_rs0[l], d, k);
      checkOutput($sformatf("byp l%0d rs0 x%0d data", l, s_rs0[l]), 64'(bus_b.gsr2id_rs0_data[l*XLEN +: XLEN]), 64'(d));
      checkOutput($sformatf("byp l%0d rs0 x%0d rdy", l, s_rs0[l]), 64'(bus_b.gsr2id_rs0_rdy[l]), 64'(k));
      refRead(1'b1, s_rs1[l], d, k);
      checkOutput($sformatf("byp l%0d rs1 x%0d data", l, s_rs1[l]), 64'(bus_b.gsr2id_rs1_data[l*XLEN +: XLEN]), 64'(d));
      checkOutput($sformatf("byp l%0d rs1 x%0d rdy", l, s_rs1[l]), 64'(bus_b.gsr2id_rs1_rdy[l]), 64'(k));
      refRead(1'b0, s_rs0[l], d, k);
      checkOutput($sformatf("nobyp l%0d rs0 x%0d data", l, s_rs0[l]), 64'(bus_n.gsr2id_rs0_data[l*XLEN +: XLEN]), 64'(d));
      checkOutput($sformatf("nobyp l%0d rs0 x%0d rdy", l, s_rs0[l]), 64'(bus_n.gsr2id_rs0_rdy[l]), 64'(k));
      refRead(1'b0, s_rs1[l], d, k);
      checkOutput($sformatf("nobyp l%0d rs1 x%0d data", l, s_rs1[l]), 64'(bus_n.gsr2id_rs1_data[l*XLEN +: XLEN]), 64'(d));
      checkOutput($sformatf("nobyp l%0d rs1 x%0d rdy", l, s_rs1[l]), 64'(bus_n.gsr2id_rs1_rdy[l]), 64'(k));
    end
  endtask

  task automatic checkCnt();
    checkOutput("byp busy_cnt", 64'(bus_b.gsr2id_busy_cnt), 64'(modelCount()));
    checkOutput("nobyp busy_cnt", 64'(bus_n.gsr2id_busy_cnt), 64'(modelCount()));
  endtask

  // One cycle: drive after the falling edge, check reads, let the edge land, check the count
  task automatic applyStimulus();
    @(negedge clk);
    drive();
    #1;
    checkReads();
    @(posedge clk);
    if (!rst) modelEdge();
    #1;
    checkCnt();
  endtask

  // Reset asserted in the middle of a cycle carrying random traffic
  task automatic midReset();
    randomStim();
    @(negedge clk);
    drive();
    #1;
    checkReads();
    #1 rst = 1'b1;
    #1;
    modelReset();
    checkReads();
    checkCnt();
    @(posedge clk);
    #1;
    checkReads();
    checkCnt();
    @(negedge clk);
    rst = 1'b0;
    clearStim();
    drive();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    modelReset();
    clearStim();

    // Reset held with a write, a set and reads of x5 active
    s_rs0 = '{5, 5};
    s_rs1 = '{5, 5};
    s_wo[0] = 5;
    s_wd[0] = 32'h1234;
    s_set[0] = 5;
    drive();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    checkReads();
    checkCnt();
    @(negedge clk);
    rst = 1'b0;
    clearStim();
    drive();

    clearStim();
    s_rs0 = '{5, 5};
    s_rs1 = '{5, 5};
    applyStimulus();
    checkOutput("x5 after reset data", 64'(bus_b.gsr2id_rs0_data[XLEN +: XLEN]), 64'h0);
    checkOutput("x5 after reset rdy", 64'(bus_b.gsr2id_rs1_rdy[1]), 64'h1);

    // Producer marking and retirement of x3
    clearStim(); s_set[0] = 3; applyStimulus();
    clearStim(); s_rs0[0] = 3; applyStimulus();
    checkOutput("x3 pending rdy", 64'(bus_b.gsr2id_rs0_rdy[0]), 64'h0);
    checkOutput("x3 pending busy_cnt", 64'(bus_b.gsr2id_busy_cnt), 64'h1);
    clearStim(); s_rs0[0] = 3; s_rs1[1] = 3; s_wo[1] = 3; s_wd[1] = 32'hDEADBEEF; applyStimulus();
    checkOutput("x3 bypass data", 64'(bus_b.gsr2id_rs0_data[0 +: XLEN]), 64'hDEADBEEF);
    checkOutput("x3 bypass rdy", 64'(bus_b.gsr2id_rs0_rdy[0]), 64'h1);
    checkOutput("x3 retired busy_cnt", 64'(bus_b.gsr2id_busy_cnt), 64'h0);
    clearStim(); s_rs0[0] = 3; applyStimulus();
    checkOutput("x3 file data", 64'(bus_n.gsr2id_rs0_data[0 +: XLEN]), 64'hDEADBEEF);
    checkOutput("x3 file rdy", 64'(bus_n.gsr2id_rs0_rdy[0]), 64'h1);

    // Two lanes writing x7: lane 0 wins
    clearStim(); s_rs0[0] = 7; s_wo = '{7, 7}; s_wd = '{32'h11, 32'h22}; applyStimulus();
    checkOutput("x7 bypass priority", 64'(bus_b.gsr2id_rs0_data[0 +: XLEN]), 64'h11);
    checkOutput("x7 file priority", 64'(bus_n.gsr2id_rs0_data[0 +: XLEN]), 64'h11);

    // Set and clear of x4 together: set wins
    clearStim(); s_rs0[0] = 4; s_set[0] = 4; s_wo[0] = 4; s_wd[0] = 32'h55; applyStimulus();
    checkOutput("x4 file data", 64'(bus_n.gsr2id_rs0_data[0 +: XLEN]), 64'h55);
    checkOutput("x4 set-wins rdy", 64'(bus_n.gsr2id_rs0_rdy[0]), 64'h0);
    checkOutput("x4 set-wins busy_cnt", 64'(bus_b.gsr2id_busy_cnt), 64'h1);

    // Several producers then a flush alongside a new set
    clearStim(); s_set[0] = 1; applyStimulus();
    clearStim(); s_set[0] = 2; applyStimulus();
    clearStim(); s_set[0] = 9; applyStimulus();
    checkOutput("pre-flush busy_cnt", 64'(bus_b.gsr2id_busy_cnt), 64'h4);
    clearStim(); s_set[1] = 10; s_flush = 1'b1; s_rs0 = '{1, 2}; s_rs1 = '{9, 10}; applyStimulus();
    checkOutput("flush busy_cnt", 64'(bus_b.gsr2id_busy_cnt), 64'h0);
    checkOutput("flush x10 rdy", 64'(bus_n.gsr2id_rs1_rdy[1]), 64'h1);

    // x0 is immune to writes and sets
    clearStim(); s_set[0] = 6; applyStimulus();
    clearStim(); s_wo[0] = 0; s_wd[0] = 32'hFFFFFFFF; s_set[0] = 0; s_rs0[0] = 0; applyStimulus();
    checkOutput("x0 data", 64'(bus_b.gsr2id_rs0_data[0 +: XLEN]), 64'h0);
    checkOutput("x0 rdy", 64'(bus_b.gsr2id_rs0_rdy[0]), 64'h1);
    checkOutput("x0 busy_cnt", 64'(bus_b.gsr2id_busy_cnt), 64'h1);

    // Without bypass a pending target being written still reads old data, not ready
    clearStim(); s_set[0] = 8; applyStimulus();
    clearStim(); s_rs0[0] = 8; s_wo[0] = 8; s_wd[0] = 32'hCAFE;
    @(negedge clk);
    drive();
    #1;
    checkOutput("nobyp x8 old data", 64'(bus_n.gsr2id_rs0_data[0 +: XLEN]), 64'h0);
    checkOutput("nobyp x8 pending rdy", 64'(bus_n.gsr2id_rs0_rdy[0]), 64'h0);
    checkReads();
    @(posedge clk);
    modelEdge();
    #1;
    checkCnt();

    // Randomized traffic with one mid-cycle reset
    for (int i = 0; i < 400; i++) begin
      if (i == 200) midReset();
      randomStim();
      applyStimulus();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
